sub_serial: RTL

Bit-serial subtractor: computes D = A − B − Bin over WIDTH bits, one bit per clock, LSB first, with borrow-out and zero flag. It is the inverse-direction companion to the team's parallel carry adder in the ALU examples. It targets area-constrained superconducting datapaths, where one full-subtractor cell plus shift registers replaces a WIDTH-wide ripple or lookahead array. Operands are presented with a start/done handshake; results are registered and held.

---
 rtl/sub_serial_pkg.sv | 25 ++
 rtl/sub_serial_if.sv | 26 ++
 rtl/sub_serial_full_sub_cell.sv | 18 +
 rtl/sub_serial.sv | 110 +++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor and any future serial ALU ops.
package sub_serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic d;
        logic bout;
    } fs_t;

    // One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
    function automatic fs_t full_sub(input logic a, input logic b, input logic bin);
        fs_t res;
        res.d    = a ^ b ^ bin;
        res.bout = (~a & b) | (~(a ^ b) & bin);
        return res;
    endfunction

endpackage

// File: rtl/sub_serial_if.sv
// Operand/result bundle for sub_serial; master drives operands, slave returns results.
interface sub_serial_if
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_d;
    logic             o_bout;
    logic             o_z;

    modport master (
        output i_start, i_a, i_b, i_bin,
        input  o_busy, o_done, o_d, o_bout, o_z
    );

    modport slave (
        input  i_start, i_a, i_b, i_bin,
        output o_busy, o_done, o_d, o_bout, o_z
    );
endinterface

// File: rtl/sub_serial_full_sub_cell.sv
// Combinational single-bit full subtractor; the only arithmetic in the serial datapath.
module full_sub_cell
    import sub_serial_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    fs_t w_res;

    always_comb begin
        w_res  = full_sub(i_a, i_b, i_bin);
        o_d    = w_res.d;
        o_bout = w_res.bout;
    end
endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit per clock, with start/done handshake.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic         clk,
    input  logic         rst,
    sub_serial_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_z;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_shift;
    logic             w_busy;
    logic             w_done;

    assign w_accept    = bus.i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    // Difference bits enter from the MSB side so bit 0 ends up at the LSB after WIDTH shifts.
    assign w_res_shift = {w_d, r_res[WIDTH-1:1]};

    full_sub_cell u_cell (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_br),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.i_start) w_state_next = RUN;
            RUN:     if (w_last)      w_state_next = DONE;
            DONE:    w_state_next = bus.i_start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == RUN);
        w_done = (r_state == DONE);
    end

    assign bus.o_busy = w_busy;
    assign bus.o_done = w_done;
    assign bus.o_d    = r_d;
    assign bus.o_bout = r_bout;
    assign bus.o_z    = r_z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= bus.i_a;
            r_b   <= bus.i_b;
            r_res <= '0;
            r_br  <= bus.i_bin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_shift;
            r_br  <= w_bout;
            if (!w_last) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Published results move only on the edge that finishes the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d    <= '0;
            r_bout <= 1'b0;
            r_z    <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_d    <= w_res_shift;
            r_bout <= w_bout;
            r_z    <= ~|w_res_shift;
        end
    end
endmodule
